// File: rtl/shift_pkg.sv
// Shared constants, the issue-register record and the shift core for the shared shift unit.
package shift_pkg;

    localparam logic OP_SLL  = 1'b0;
    localparam logic OP_SRA  = 1'b1;
    localparam logic TAG_ALU = 1'b0;
    localparam logic TAG_MDU = 1'b1;
    localparam int   SHAMT_W = 5;

    typedef struct packed {
        logic [31:0]        a;
        logic [SHAMT_W-1:0] shamt;
        logic               op;
        logic               tag;
    } issue_t;

    // The one shift core of the unit: logical left or arithmetic right.
    function automatic logic [31:0] shift_core(input logic [31:0] a,
                                               input logic [SHAMT_W-1:0] shamt,
                                               input logic op);
        logic [31:0] res;
        if (op == OP_SRA) res = $signed(a) >>> shamt;
        else              res = a << shamt;
        return res;
    endfunction

endpackage

// File: rtl/shift_unit_arbiter_rr.sv
// Two-input arbiter with a priority pointer; reusable by any unit shared by two requesters.
module rr_arbiter_2 #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;
    logic accept;

    // A lone requester always wins; on contention the pointer port wins.
    always_comb begin
        grant    = 2'b00;
        grant[1] = req[1] & (~req[0] | ptr);
        grant[0] = req[0] & ~grant[1];
    end

    assign accept = advance & (req[0] | req[1]);

    // Pointer moves to the port that did not win, so the loser gets the next tie.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= 1'b0;
        end else if ((ROUND_ROBIN != 0) && accept) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/shift_unit_arbiter.sv
// One 32-bit SLL/SRA datapath shared by the ALU (port 0) and multdiv (port 1):
// arbitration into an issue register, then a result register driving the tagged output.
module shift_unit_arbiter
    import shift_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ROUND_ROBIN = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in0_valid,
    output logic               in0_ready,
    input  logic [DATA_W-1:0]  in0_a,
    input  logic [SHAMT_W-1:0] in0_shamt,
    input  logic               in0_op,
    input  logic               in1_valid,
    output logic               in1_ready,
    input  logic [DATA_W-1:0]  in1_a,
    input  logic [SHAMT_W-1:0] in1_shamt,
    input  logic               in1_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_tag
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // ready never depends on anything but valid, downstream ready and pipeline occupancy.
    issue_t     s1;
    issue_t     req_sel;
    logic       s1_valid;
    logic       s2_valid;
    logic       advance_s1;
    logic       advance_s2;
    logic       accept;
    logic [1:0] grant;

    assign advance_s2 = ~s2_valid | out_ready;
    assign advance_s1 = ~s1_valid | advance_s2;

    rr_arbiter_2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     ({in1_valid, in0_valid}),
        .advance (advance_s1),
        .grant   (grant)
    );

    // Readies are held low while reset is asserted even though the stages look empty.
    assign in0_ready = grant[0] & advance_s1 & reset_n;
    assign in1_ready = grant[1] & advance_s1 & reset_n;
    assign accept    = in0_ready | in1_ready;

    always_comb begin
        req_sel = '{a: in0_a, shamt: in0_shamt, op: in0_op, tag: TAG_ALU};
        if (grant[1]) begin
            req_sel = '{a: in1_a, shamt: in1_shamt, op: in1_op, tag: TAG_MDU};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1       <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            out_data <= '0;
            out_tag  <= 1'b0;
        end else begin
            if (advance_s1) begin
                s1_valid <= accept;
                if (accept) s1 <= req_sel;
            end
            if (advance_s2) begin
                s2_valid <= s1_valid;
                out_data <= shift_core(s1.a, s1.shamt, s1.op);
                out_tag  <= s1.tag;
            end
        end
    end

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Bench for shift_unit_arbiter: a round-robin instance against a queue-based model and a
// fixed-priority instance (always ready downstream) against a two-deep delay model.
module tb_shift_unit_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in0_valid = 1'b0, in1_valid = 1'b0;
    logic [31:0] in0_a = '0, in1_a = '0;
    logic [4:0]  in0_shamt = '0, in1_shamt = '0;
    logic        in0_op = 1'b0, in1_op = 1'b0;
    logic        out_ready = 1'b1;

    logic        in0_ready, in1_ready, out_valid, out_tag;
    logic [31:0] out_data;
    logic        b_in0_ready, b_in1_ready, b_out_valid, b_out_tag;
    logic [31:0] b_out_data;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    shift_unit_arbiter #(.DATA_W(32), .ROUND_ROBIN(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_a(in0_a),
        .in0_shamt(in0_shamt), .in0_op(in0_op),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_a(in1_a),
        .in1_shamt(in1_shamt), .in1_op(in1_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    shift_unit_arbiter #(.DATA_W(32), .ROUND_ROBIN(0)) dut_fixed (
        .clock(clock), .reset_n(reset_n),
        .in0_valid(in0_valid), .in0_ready(b_in0_ready), .in0_a(in0_a),
        .in0_shamt(in0_shamt), .in0_op(in0_op),
        .in1_valid(in1_valid), .in1_ready(b_in1_ready), .in1_a(in1_a),
        .in1_shamt(in1_shamt), .in1_op(in1_op),
        .out_valid(b_out_valid), .out_ready(1'b1),
        .out_data(b_out_data), .out_tag(b_out_tag)
    );

    // Model state: in-flight items as {accept_edge[15:0], tag, data[31:0]}.
    logic [48:0] exp_q[$];
    logic        m_ptr = 1'b0;
    int          edge_cnt = 0;
    int          dut_acc = 0;
    logic [32:0] b_d1 = '0, b_d2 = '0;
    logic        b_v1 = 1'b0, b_v2 = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s,
                                              input logic op);
        logic [63:0] prod;
        if (op) return a[31] ? ~((~a) >> s) : (a >> s);
        prod = {32'b0, a} * (64'd1 << s);
        return prod[31:0];
    endfunction

    // Called at a negedge with inputs already driven; returns at the following negedge.
    task automatic step();
        logic can, g0, g1, er0, er1, ov, bw;
        logic [31:0] bres;
        #1;
        can = (exp_q.size() < 2) || out_ready;
        g1  = in1_valid && (!in0_valid || m_ptr);
        g0  = in0_valid && !g1;
        er0 = g0 && can;
        er1 = g1 && can;
        ov  = (exp_q.size() > 0) && (int'(exp_q[0][48:33]) + 1 < edge_cnt);
        check_eq("in0_ready", {31'b0, in0_ready}, {31'b0, er0});
        check_eq("in1_ready", {31'b0, in1_ready}, {31'b0, er1});
        check_eq("out_valid", {31'b0, out_valid}, {31'b0, ov});
        if (ov) begin
            check_eq("out_data", out_data, exp_q[0][31:0]);
            check_eq("out_tag", {31'b0, out_tag}, {31'b0, exp_q[0][32]});
        end
        check_eq("fixed_in0_ready", {31'b0, b_in0_ready}, {31'b0, in0_valid});
        check_eq("fixed_in1_ready", {31'b0, b_in1_ready}, {31'b0, in1_valid && !in0_valid});
        check_eq("fixed_out_valid", {31'b0, b_out_valid}, {31'b0, b_v2});
        if (b_v2) begin
            check_eq("fixed_out_data", b_out_data, b_d2[31:0]);
            check_eq("fixed_out_tag", {31'b0, b_out_tag}, {31'b0, b_d2[32]});
        end
        if (in0_ready || in1_ready) dut_acc++;
        bw   = !in0_valid;
        bres = bw ? ref_shift(in1_a, in1_shamt, in1_op) : ref_shift(in0_a, in0_shamt, in0_op);
        @(posedge clock);
        if (ov && out_ready) void'(exp_q.pop_front());
        if (er0) exp_q.push_back({16'(edge_cnt), 1'b0, ref_shift(in0_a, in0_shamt, in0_op)});
        if (er1) exp_q.push_back({16'(edge_cnt), 1'b1, ref_shift(in1_a, in1_shamt, in1_op)});
        if (er0 || er1) m_ptr = g0;
        b_v2 = b_v1;
        b_d2 = b_d1;
        b_v1 = in0_valid || in1_valid;
        b_d1 = {bw, bres};
        edge_cnt++;
        @(negedge clock);
    endtask

    task automatic drive(input logic v0, input logic v1, input logic ordy);
        in0_valid = v0;
        in1_valid = v1;
        out_ready = ordy;
    endtask

    task automatic rand_operands();
        in0_a = $urandom;
        in1_a = $urandom;
        in0_op = 1'($urandom_range(0, 1));
        in1_op = 1'($urandom_range(0, 1));
        in0_shamt = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 1) * 31)
                                                : 5'($urandom_range(0, 31));
        in1_shamt = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 1) * 31)
                                                : 5'($urandom_range(0, 31));
    endtask

    task automatic drain();
        drive(1'b0, 1'b0, 1'b1);
        repeat (3) step();
    endtask

    task automatic clear_model();
        exp_q.delete();
        m_ptr = 1'b0;
        b_v1 = 1'b0;
        b_v2 = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clock);
        #1;
        check_eq("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("reset_out_data", out_data, 32'd0);
        check_eq("reset_out_tag", {31'b0, out_tag}, 32'd0);
        drive(1'b1, 1'b1, 1'b1);
        #1;
        check_eq("reset_in0_ready", {31'b0, in0_ready}, 32'd0);
        check_eq("reset_in1_ready", {31'b0, in1_ready}, 32'd0);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b1);
        reset_n = 1'b1;
        step();

        // Single ALU request, SLL by 4
        in0_a = 32'h0000_0001; in0_shamt = 5'd4; in0_op = 1'b0;
        drive(1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b1);
        step();
        check_eq("t1_out_valid", {31'b0, out_valid}, 32'd1);
        check_eq("t1_out_data", out_data, 32'h0000_0010);
        check_eq("t1_out_tag", {31'b0, out_tag}, 32'd0);
        drain();

        // Boundary shift amounts
        in1_a = 32'h8000_0000; in1_shamt = 5'd31; in1_op = 1'b1;
        drive(1'b0, 1'b1, 1'b1);
        step();
        in0_a = 32'h1234_5678; in0_shamt = 5'd0; in0_op = 1'b0;
        drive(1'b1, 1'b0, 1'b1);
        step();
        check_eq("t3_sra31_data", out_data, 32'hFFFF_FFFF);
        check_eq("t3_sra31_tag", {31'b0, out_tag}, 32'd1);
        drive(1'b0, 1'b0, 1'b1);
        step();
        check_eq("t3_shamt0_data", out_data, 32'h1234_5678);
        check_eq("t3_shamt0_tag", {31'b0, out_tag}, 32'd0);
        drain();

        // Both ports streaming, full throughput alternation
        drive(1'b1, 1'b1, 1'b1);
        repeat (10) begin
            rand_operands();
            step();
        end
        drain();

        // Backpressure: five stalled cycles admit exactly two requests
        dut_acc = 0;
        drive(1'b1, 1'b1, 1'b0);
        repeat (5) begin
            rand_operands();
            step();
        end
        check_eq("t4_accepts", 32'(dut_acc), 32'd2);
        drive(1'b0, 1'b0, 1'b1);
        repeat (4) step();
        check_eq("t4_drained", 32'(exp_q.size()), 32'd0);

        // Fixed-priority instance: port 1 only when port 0 drops
        drive(1'b1, 1'b1, 1'b1);
        repeat (4) begin
            rand_operands();
            step();
        end
        drive(1'b0, 1'b1, 1'b1);
        step();
        drain();

        // Reset with both stages full
        drive(1'b1, 1'b1, 1'b0);
        rand_operands();
        step();
        step();
        check_eq("t5_full_out_valid", {31'b0, out_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("t5_reset_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("t5_reset_in0_ready", {31'b0, in0_ready}, 32'd0);
        check_eq("t5_reset_fixed_valid", {31'b0, b_out_valid}, 32'd0);
        clear_model();
        @(negedge clock);
        reset_n = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        #1;
        check_eq("t5_first_grant0", {31'b0, in0_ready}, 32'd1);
        check_eq("t5_first_grant1", {31'b0, in1_ready}, 32'd0);
        step();
        step();

        // Randomized traffic with random backpressure
        repeat (600) begin
            rand_operands();
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0));
            step();
        end
        drive(1'b0, 1'b0, 1'b1);
        repeat (4) step();
        check_eq("final_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
